pc_gen_unit: RTL and testbench

- Parametrised next-PC generator for the NPC fetch stage; replaces the fixed sequential +4 adder.
- Holds the architectural fetch PC and selects the next PC: sequential step, branch/jump redirect, trap entry or trap return.
- Presents the PC to the IFU over a valid/ready handshake and supports pipeline stalls.
- Buffers one redirect that arrives while the front end is stalled.

---
 rtl/pc_gen_unit.sv | 113 +++++++++++
 tb/tb_pc_gen_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: next-PC generator for the fetch stage.
// Holds the fetch PC, steps it sequentially on IFU acceptance, and redirects
// on trap entry / trap return / branch. A redirect seen while stalled is
// parked in a single-entry buffer and applied on the first unstalled cycle.
// Optional feature macro: PC_MISALIGN_CHECK_EN
//   defined   -> targets loaded as-is, misalign_o flags pc_o[1:0] != 0
//   undefined -> targets have bit0 cleared (JALR semantics), no misalign_o
module pc_gen_unit #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(32'h8000_0000),
  parameter int                   PC_STEP   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 ifu_ready_i,
  input  logic                 br_taken_i,
  input  logic [CPU_WIDTH-1:0] br_target_i,
  input  logic                 trap_i,
  input  logic [CPU_WIDTH-1:0] mtvec_i,
  input  logic                 mret_i,
  input  logic [CPU_WIDTH-1:0] mepc_i,
  output logic [CPU_WIDTH-1:0] pc_o,
  output logic                 pc_valid_o,
  output logic                 redirect_o
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic                 misalign_o
`endif
);

  localparam logic [0:0] S_BOOT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           state;
  logic                 pend_v,   pend_v_nxt;
  logic [CPU_WIDTH-1:0] pend_pc,  pend_pc_nxt;
  logic [CPU_WIDTH-1:0] pc_nxt;
  logic                 redir_nxt;
  logic                 req;
  logic [CPU_WIDTH-1:0] sel_tgt, tgt;

  assign pc_valid_o = (state == S_RUN);
  assign req        = trap_i | mret_i | br_taken_i;

  // Priority select of the redirect target: trap > mret > branch
  always_comb begin
    sel_tgt = br_target_i;
    if (mret_i) sel_tgt = mepc_i;
    if (trap_i) sel_tgt = mtvec_i;
`ifdef PC_MISALIGN_CHECK_EN
    tgt = sel_tgt;
`else
    tgt = sel_tgt & ~CPU_WIDTH'(1);
`endif
  end

  // Next-PC / pending-buffer decision; a fresh redirect beats a buffered one
  always_comb begin
    pc_nxt      = pc_o;
    redir_nxt   = 1'b0;
    pend_v_nxt  = pend_v;
    pend_pc_nxt = pend_pc;
    if (req) begin
      if (stall_i) begin
        pend_v_nxt  = 1'b1;
        pend_pc_nxt = tgt;
      end else begin
        pc_nxt     = tgt;
        redir_nxt  = 1'b1;
        pend_v_nxt = 1'b0;
      end
    end else if (pend_v) begin
      if (!stall_i) begin
        pc_nxt     = pend_pc;
        redir_nxt  = 1'b1;
        pend_v_nxt = 1'b0;
      end
    end else if (state == S_RUN && ifu_ready_i && !stall_i) begin
      pc_nxt = pc_o + CPU_WIDTH'(PC_STEP);
    end
  end

  // BOOT lasts exactly one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= S_RUN;
  end

  // PC, redirect pulse and pending buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o       <= RESET_PC;
      redirect_o <= 1'b0;
      pend_v     <= 1'b0;
      pend_pc    <= '0;
    end else begin
      pc_o       <= pc_nxt;
      redirect_o <= redir_nxt;
      pend_v     <= pend_v_nxt;
      pend_pc    <= pend_pc_nxt;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // Misalign flag registered alongside pc_o so it always describes pc_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_o <= (RESET_PC[1:0] != 2'b00);
    else        misalign_o <= (pc_nxt[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed table-driven bench for pc_gen_unit (CPU_WIDTH=32).
module tb_pc_gen_unit;

  logic        clk, rst_n;
  logic        stall_i, ifu_ready_i, br_taken_i, trap_i, mret_i;
  logic [31:0] br_target_i, mtvec_i, mepc_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, redirect_o;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_o;
  localparam logic [31:0] MIS_PC = 32'h8000_0003;
`else
  localparam logic [31:0] MIS_PC = 32'h8000_0002;
`endif

  pc_gen_unit #(.CPU_WIDTH(32), .RESET_PC(32'h8000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ifu_ready_i(ifu_ready_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i), .trap_i(trap_i),
    .mtvec_i(mtvec_i), .mret_i(mret_i), .mepc_i(mepc_i), .pc_o(pc_o),
    .pc_valid_o(pc_valid_o), .redirect_o(redirect_o)
`ifdef PC_MISALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, ready, trap, mret, br;
    logic [31:0] mepc, br_tgt;
    logic [31:0] exp_pc;
    logic        exp_redir;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0, n_total = 0;

  function automatic vec_t mk(logic stall, logic ready, logic trap, logic mret,
                              logic br, logic [31:0] mepc, logic [31:0] br_tgt,
                              logic [31:0] exp_pc, logic exp_redir, logic exp_mis);
    vec_t v;
    v.stall = stall; v.ready = ready; v.trap = trap; v.mret = mret; v.br = br;
    v.mepc = mepc; v.br_tgt = br_tgt; v.exp_pc = exp_pc;
    v.exp_redir = exp_redir; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle();
    stall_i = 0; ifu_ready_i = 0; br_taken_i = 0; trap_i = 0; mret_i = 0;
    br_target_i = '0; mepc_i = '0; mtvec_i = 32'h8000_1000;
  endtask

  initial begin
    // stall ready trap mret br  mepc          br_tgt        exp_pc        rd mis
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0000,0,0)); // BOOT->RUN, no step
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0004,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0008,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_000C,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0010,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,            0,            32'h8000_0010,0,0)); // backpressure x4
    vecs.push_back(mk(0,0,0,0,0, 0,            0,            32'h8000_0010,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,            0,            32'h8000_0010,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,            0,            32'h8000_0010,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0014,0,0));
    vecs.push_back(mk(0,1,1,1,1, 32'h8000_0300,32'h8000_0200,32'h8000_1000,1,0)); // trap wins
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_1004,0,0));
    vecs.push_back(mk(0,0,0,1,0, 32'h8000_0300,0,            32'h8000_0300,1,0)); // mret, not accepted
    vecs.push_back(mk(0,0,0,1,1, 32'h8000_0600,32'h8000_0200,32'h8000_0600,1,0)); // mret beats br
    vecs.push_back(mk(1,0,0,0,1, 0,            32'h8000_0400,32'h8000_0600,0,0)); // stalled redirect
    vecs.push_back(mk(1,0,0,0,0, 0,            0,            32'h8000_0600,0,0));
    vecs.push_back(mk(1,0,0,0,1, 0,            32'h8000_0500,32'h8000_0600,0,0)); // overwrite buffer
    vecs.push_back(mk(1,0,0,0,0, 0,            0,            32'h8000_0600,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,            0,            32'h8000_0600,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0500,1,0)); // release
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0504,0,0));
    vecs.push_back(mk(1,1,1,0,0, 0,            0,            32'h8000_0504,0,0)); // trap parked
    vecs.push_back(mk(0,1,0,0,1, 0,            32'h8000_0700,32'h8000_0700,1,0)); // new beats buffer
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h8000_0704,0,0)); // buffer was cleared
    vecs.push_back(mk(0,1,0,0,1, 0,            32'hFFFF_FFFC,32'hFFFF_FFFC,1,0));
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h0000_0000,0,0)); // wrap
    vecs.push_back(mk(0,1,0,0,0, 0,            0,            32'h0000_0004,0,0));
    vecs.push_back(mk(1,1,0,0,0, 0,            0,            32'h0000_0004,0,0)); // stall freezes
    vecs.push_back(mk(0,0,0,0,1, 0,            32'h8000_0003,MIS_PC,       1,1)); // misaligned target
    vecs.push_back(mk(0,0,0,0,1, 0,            32'h8000_0003,MIS_PC,       1,1)); // back-to-back redirects
    vecs.push_back(mk(0,1,0,0,1, 0,            32'h8000_0008,32'h8000_0008,1,0));

    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc",    pc_o,       32'h8000_0000);
    chk("reset_valid", {31'b0, pc_valid_o}, 32'd0);
    chk("reset_redir", {31'b0, redirect_o}, 32'd0);
    rst_n = 1;
    #2;
    chk("boot_valid",  {31'b0, pc_valid_o}, 32'd0);

    foreach (vecs[i]) begin
      stall_i = vecs[i].stall; ifu_ready_i = vecs[i].ready;
      trap_i = vecs[i].trap; mret_i = vecs[i].mret; br_taken_i = vecs[i].br;
      mepc_i = vecs[i].mepc; br_target_i = vecs[i].br_tgt;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i),    pc_o,                    vecs[i].exp_pc);
      chk($sformatf("v%0d_valid", i), {31'b0, pc_valid_o},     32'd1);
      chk($sformatf("v%0d_redir", i), {31'b0, redirect_o},     {31'b0, vecs[i].exp_redir});
`ifdef PC_MISALIGN_CHECK_EN
      chk($sformatf("v%0d_mis", i),   {31'b0, misalign_o},     {31'b0, vecs[i].exp_mis});
`endif
    end

    // Mid-operation async reset: takes effect without a clock edge
    idle();
    ifu_ready_i = 1;
    #3;
    rst_n = 0;
    #1;
    chk("midrst_pc",    pc_o,                32'h8000_0000);
    chk("midrst_valid", {31'b0, pc_valid_o}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_hold_pc", pc_o,              32'h8000_0000);
    rst_n = 1;
    // Redirect issued during BOOT is honoured
    br_taken_i = 1; br_target_i = 32'h8000_0100;
    @(posedge clk); #1;
    chk("boot_redir_pc",    pc_o,                32'h8000_0100);
    chk("boot_redir_pulse", {31'b0, redirect_o}, 32'd1);
    chk("boot_redir_valid", {31'b0, pc_valid_o}, 32'd1);
    br_taken_i = 0;
    @(posedge clk); #1;
    chk("post_boot_pc",    pc_o,                32'h8000_0104);
    chk("post_boot_pulse", {31'b0, redirect_o}, 32'd0);

    // Trap target has bit0 forced only without the misalign feature
    mtvec_i = 32'h8000_2001; trap_i = 1; stall_i = 1;
    @(posedge clk); #1;
    trap_i = 0;
    chk("trap_park_pc", pc_o, 32'h8000_0104);
    repeat (2) begin @(posedge clk); #1; end
    chk("trap_park_hold", pc_o, 32'h8000_0104);
    stall_i = 0;
    @(posedge clk); #1;
`ifdef PC_MISALIGN_CHECK_EN
    chk("trap_release_pc", pc_o, 32'h8000_2001);
`else
    chk("trap_release_pc", pc_o, 32'h8000_2000);
`endif
    chk("trap_release_pulse", {31'b0, redirect_o}, 32'd1);
    @(posedge clk); #1;
    chk("trap_release_once", {31'b0, redirect_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
